// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write port,
// bulk-clear handshake and the mirrored register output.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  clr_req;
  logic                  busy;
  logic [DATA_W-1:0]     ret_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, busy, ret_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, busy, ret_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, optional hard-wired zero
// register and a one-register-per-cycle bulk clear sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int RET_IDX  = (2**ADDR_W) - 1,
  parameter int ZERO_REG = 1
) (
  input  logic       clk,
  input  logic       rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] RET_A = ADDR_W'(RET_IDX);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic                busy_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_hit;
  logic                we;
  logic [ADDR_W-1:0]   we_addr;
  logic [DATA_W-1:0]   we_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next == CLEAR);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + ADDR_W'(1);
        if (&cnt_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The sweep owns the single write port while clearing; user writes are dropped.
  always_comb begin
    wr_hit  = 1'b0;
    we      = 1'b0;
    we_addr = bus.wr_addr;
    we_data = bus.wr_data;
    case (state_reg)
      IDLE: begin
        wr_hit = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
        we     = wr_hit;
      end
      CLEAR: begin
        we      = 1'b1;
        we_addr = cnt_reg;
        we_data = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[we_addr] <= we_data;
    end
  end

  wire [NRD*DATA_W-1:0] rd_flat;

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] word;

      assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        if ((ZERO_REG != 0) && (addr == '0))
          word = '0;
        else if (wr_hit && (bus.wr_addr == addr))
          word = bus.wr_data;
        else
          word = mem[addr];
      end

      assign rd_flat[gi*DATA_W +: DATA_W] = word;
    end
  endgenerate

  assign bus.rd_data  = rd_flat;
  assign bus.ret_data = mem[RET_A];
  assign bus.busy     = busy_reg;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp, checked against an
// array-based reference model of the register file and clear sweep.
module tb_regfile_mp;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NRD     = 2;
  localparam int DEPTH   = 32;
  localparam int RET_IDX = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .RET_IDX(RET_IDX), .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int busy_seen = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  int clear_left = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int a);
    if (a == 0) return '0;
    if (clear_left == 0 && bus.wr_en && int'(bus.wr_addr) == a) return bus.wr_data;
    return model_mem[a];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    clear_left = 0;
  endfunction

  function automatic void model_edge();
    if (clear_left > 0) begin
      model_mem[DEPTH - clear_left] = '0;
      clear_left--;
    end else begin
      if (bus.wr_en && bus.wr_addr != 0) model_mem[bus.wr_addr] = bus.wr_data;
      if (bus.clr_req) clear_left = DEPTH;
    end
  endfunction

  task automatic set_in(input bit we, input int wa, input logic [DATA_W-1:0] wd,
                        input bit clr, input int a0, input int a1);
    bus.wr_en   = we;
    bus.wr_addr = ADDR_W'(wa);
    bus.wr_data = wd;
    bus.clr_req = clr;
    bus.rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  // One transaction: check combinational outputs mid-cycle, then advance model on the edge.
  task automatic cycle(input string tag);
    #1;
    $display("[TB] %s we=%0b wa=%0d wd=%0h clr=%0b ra=%0h rd=%0h busy=%0b ret=%0h",
             tag, bus.wr_en, bus.wr_addr, bus.wr_data, bus.clr_req, bus.rd_addr,
             bus.rd_data, bus.busy, bus.ret_data);
    for (int k = 0; k < NRD; k++)
      check($sformatf("%s rd%0d", tag, k), 64'(bus.rd_data[k*DATA_W +: DATA_W]),
            64'(model_read(int'(bus.rd_addr[k*ADDR_W +: ADDR_W]))));
    check({tag, " busy"}, 64'(bus.busy), 64'(clear_left > 0));
    check({tag, " ret"}, 64'(bus.ret_data), 64'(model_mem[RET_IDX]));
    if (bus.busy) busy_seen++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    set_in(0, 0, '0, 0, 7, 31);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset rd", 64'(bus.rd_data), 64'(0));
    check("reset ret", 64'(bus.ret_data), 64'(0));
    @(negedge clk) rst = 1'b1;

    // Bypass and plain read-back
    set_in(1, 1, 36, 0, 1, 5);   cycle("wr1");
    set_in(0, 0, 0, 0, 1, 5);    cycle("rd1");

    // Zero register and ret_data latency
    set_in(1, 0, 63, 0, 0, 0);   cycle("wr0");
    set_in(0, 0, 0, 0, 0, 0);    cycle("rd0");
    set_in(1, 31, 69, 0, 31, 0); cycle("wrret");
    set_in(0, 0, 0, 0, 31, 0);   cycle("rdret");

    // Fill then full sweep
    for (int i = 1; i < DEPTH; i++) begin
      set_in(1, i, DATA_W'(i*3), 0, i, 10);
      cycle("fill");
    end
    set_in(0, 0, 0, 1, 10, 10);
    busy_seen = 0;
    cycle("clr");
    set_in(0, 0, 0, 0, 10, 31);
    repeat (34) cycle("sweep");
    check("sweep busy_len", 64'(busy_seen), 64'(32));
    for (int i = 0; i < DEPTH; i++) begin
      set_in(0, 0, 0, 0, i, DEPTH-1-i);
      cycle("post");
    end

    // Writes and clr_req ignored during the sweep
    set_in(1, 2, 32'h22, 0, 2, 2); cycle("wr2");
    set_in(0, 0, 0, 1, 2, 2);
    busy_seen = 0;
    cycle("clr2");
    for (int j = 0; j < DEPTH; j++) begin
      set_in(1, 2, 32'hDEAD, (j % 4) == 1, 2, 3);
      cycle("ign");
    end
    set_in(0, 0, 0, 0, 2, 3);      cycle("ignend");
    check("ignore busy_len", 64'(busy_seen), 64'(32));

    // Same-cycle write and clear
    busy_seen = 0;
    set_in(1, 31, 7, 1, 31, 31);   cycle("wrclr");
    set_in(0, 0, 0, 0, 31, 30);
    repeat (33) cycle("wrclr_sw");
    check("wrclr busy_len", 64'(busy_seen), 64'(32));

    // Asynchronous reset mid-sweep
    set_in(1, 3, 32'h33, 0, 3, 20);  cycle("pre3");
    set_in(1, 20, 32'h20, 0, 3, 20); cycle("pre20");
    set_in(1, 31, 32'h99, 0, 3, 20); cycle("pre31");
    set_in(0, 0, 0, 1, 3, 20);       cycle("clr3");
    set_in(0, 0, 0, 0, 3, 20);
    repeat (12) cycle("part");
    #3 rst = 1'b0;
    #1;
    check("arst busy", 64'(bus.busy), 64'(0));
    check("arst rd0", 64'(bus.rd_data[0 +: DATA_W]), 64'(0));
    check("arst rd1", 64'(bus.rd_data[DATA_W +: DATA_W]), 64'(0));
    check("arst ret", 64'(bus.ret_data), 64'(0));
    model_reset();
    @(negedge clk) rst = 1'b1;
    set_in(1, 3, 5, 0, 3, 20);   cycle("rel_wr");
    set_in(0, 0, 0, 0, 3, 20);   cycle("rel_rd");

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      int wa;
      wa = int'($urandom_range(0, DEPTH-1));
      set_in(bit'($urandom_range(0, 1)), wa, $urandom, $urandom_range(0, 49) == 0,
             ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, DEPTH-1)),
             int'($urandom_range(0, DEPTH-1)));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
